// File: rtl/dsp_pipe_delay.sv
// -----------------------------------------------------------------------------
// dsp_pipe_delay
//
// Parametrised pipeline delay line for the DSP slice datapath. Each of the DEPTH
// register stages carries a data word plus a valid bit, so consumers get
// data/valid alignment, an occupancy count of valid words in flight and a busy
// (drain) indication. DEPTH = 0 degenerates to a combinational bypass.
//
// Optional feature (compile-time macro PIPE_PARITY_EN):
//   Each stage carries an even-parity bit generated at stage 0. A sticky,
//   registered parity_err output flags a word that leaves the pipe with a
//   parity mismatch. Without the macro there are no parity bits and no
//   parity_err port; timing is identical either way.
//
// Parameters:
//   WIDTH    data width in bits (1..64)
//   DEPTH    number of register stages (0..16), 0 = combinational bypass
//   CLR_DATA 1: SCLR zeroes the data stages too; 0: SCLR clears valids only
//   CNT_W    derived internally as max(1, clog2(DEPTH+1))
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous reset, active-high
//   CE         in   clock enable; 0 freezes stages, valids and occ
//   SCLR       in   synchronous clear, active-high, only honoured with CE=1
//   in_valid   in   input qualifier
//   in_data    in   input word [WIDTH]
//   out_valid  out  valid bit of the last stage
//   out_data   out  data of the last stage [WIDTH]
//   occ        out  number of stages holding a valid word [CNT_W]
//   busy       out  occ != 0
//   parity_err out  sticky parity error (PIPE_PARITY_EN only)
// -----------------------------------------------------------------------------
module dsp_pipe_delay #(
    parameter int WIDTH    = 48,
    parameter int DEPTH    = 2,
    parameter int CLR_DATA = 1
) (
    input  logic                                              CLK,
    input  logic                                              RST,
    input  logic                                              CE,
    input  logic                                              SCLR,
    input  logic                                              in_valid,
    input  logic [WIDTH-1:0]                                  in_data,
    output logic                                              out_valid,
    output logic [WIDTH-1:0]                                  out_data,
    output logic [((DEPTH < 1) ? 1 : $clog2(DEPTH + 1))-1:0]  occ,
    output logic                                              busy
`ifdef PIPE_PARITY_EN
    ,
    output logic                                              parity_err
`endif
);

    localparam int CNT_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

`ifdef PIPE_PARITY_EN
    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_par_f(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    if (DEPTH == 0) begin : g_bypass

        // Pure wire-through; control inputs have no effect on the data path.
        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign occ       = {CNT_W{1'b0}};
        assign busy      = 1'b0;
`ifdef PIPE_PARITY_EN
        assign parity_err = 1'b0;
`endif
        // Control inputs are intentionally ignored in the bypass configuration.
        logic unused_ctrl_s;
        assign unused_ctrl_s = ^{CLK, RST, CE, SCLR};

    end else begin : g_pipe

        // Stage DEPTH-1 is the output stage.
        logic [WIDTH-1:0] data_r      [DEPTH];
        logic [WIDTH-1:0] data_nxt_s  [DEPTH];
        logic [DEPTH-1:0] valid_r;
        logic [DEPTH-1:0] valid_nxt_s;
        logic [CNT_W-1:0] occ_r;
        logic [CNT_W-1:0] occ_nxt_s;
        logic             clr_data_s;

        assign clr_data_s = SCLR && (CLR_DATA != 0);

        // Next-state of the shift chain: normal shift, or clear on SCLR.
        always_comb begin
            data_nxt_s[0] = clr_data_s ? {WIDTH{1'b0}} : in_data;
            for (int k = 1; k < DEPTH; k++) begin
                data_nxt_s[k] = clr_data_s ? {WIDTH{1'b0}} : data_r[k-1];
            end

            // The word presented on an SCLR edge is discarded (valid forced 0).
            valid_nxt_s[0] = SCLR ? 1'b0 : in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                valid_nxt_s[k] = SCLR ? 1'b0 : valid_r[k-1];
            end

            // Occupancy tracks entries minus exits; since it mirrors the count
            // of set valid bits it is bounded to 0..DEPTH by construction.
            occ_nxt_s = SCLR ? {CNT_W{1'b0}}
                             : (occ_r + CNT_W'(in_valid) - CNT_W'(valid_r[DEPTH-1]));
        end

        // Stage, valid and occupancy registers; CE=0 holds everything.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int k = 0; k < DEPTH; k++) begin
                    data_r[k] <= {WIDTH{1'b0}};
                end
                valid_r <= {DEPTH{1'b0}};
                occ_r   <= {CNT_W{1'b0}};
            end else if (CE) begin
                for (int k = 0; k < DEPTH; k++) begin
                    data_r[k] <= data_nxt_s[k];
                end
                valid_r <= valid_nxt_s;
                occ_r   <= occ_nxt_s;
            end else begin
                valid_r <= valid_r;
                occ_r   <= occ_r;
            end
        end

        assign out_data  = data_r[DEPTH-1];
        assign out_valid = valid_r[DEPTH-1];
        assign occ       = occ_r;
        assign busy      = (occ_r != {CNT_W{1'b0}});

`ifdef PIPE_PARITY_EN
        logic [DEPTH-1:0] par_r;
        logic [DEPTH-1:0] par_nxt_s;
        logic             par_flip_s;
        logic             par_mismatch_s;
        logic             parity_err_r;

        // Fault-injection hook for verification: normally tied low, a bench
        // may force it to corrupt the parity bit captured in stage 0.
        assign par_flip_s = 1'b0;

        // Parity chain follows the data chain, including the SCLR data clear.
        always_comb begin
            par_nxt_s[0] = clr_data_s ? 1'b0 : (even_par_f(in_data) ^ par_flip_s);
            for (int k = 1; k < DEPTH; k++) begin
                par_nxt_s[k] = clr_data_s ? 1'b0 : par_r[k-1];
            end
        end

        // Parity bit registers.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                par_r <= {DEPTH{1'b0}};
            end else if (CE) begin
                par_r <= par_nxt_s;
            end else begin
                par_r <= par_r;
            end
        end

        assign par_mismatch_s = valid_r[DEPTH-1]
                              && (even_par_f(data_r[DEPTH-1]) != par_r[DEPTH-1]);

        // Sticky error flag; SCLR clear wins over a same-edge detection.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                parity_err_r <= 1'b0;
            end else if (CE) begin
                if (SCLR) begin
                    parity_err_r <= 1'b0;
                end else if (par_mismatch_s) begin
                    parity_err_r <= 1'b1;
                end else begin
                    parity_err_r <= parity_err_r;
                end
            end else begin
                parity_err_r <= parity_err_r;
            end
        end

        assign parity_err = parity_err_r;
`endif

    end

endmodule

// File: tb/tb_dsp_pipe_delay.sv
// -----------------------------------------------------------------------------
// tb_dsp_pipe_delay
//
// Three instances share one stimulus: u_a (DEPTH=3, CLR_DATA=1), u_b (DEPTH=3,
// CLR_DATA=0) and u_z (DEPTH=0 bypass). Each CE-qualified edge pushes the driven
// word into a per-instance expectation queue and retires the oldest entry; the
// head of the queue is the word expected at the output.
// -----------------------------------------------------------------------------
module tb_dsp_pipe_delay;

    localparam int W = 48;

    logic         CLK;
    logic         RST;
    logic         CE;
    logic         SCLR;
    logic         in_valid;
    logic [W-1:0] in_data;

    logic         a_out_valid, b_out_valid, z_out_valid;
    logic [W-1:0] a_out_data, b_out_data, z_out_data;
    logic [1:0]   a_occ, b_occ;
    logic [0:0]   z_occ;
    logic         a_busy, b_busy, z_busy;
`ifdef PIPE_PARITY_EN
    logic         a_perr, b_perr, z_perr;
`endif

    dsp_pipe_delay #(.WIDTH(W), .DEPTH(3), .CLR_DATA(1)) u_a (
        .CLK(CLK), .RST(RST), .CE(CE), .SCLR(SCLR),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(a_out_valid), .out_data(a_out_data),
        .occ(a_occ), .busy(a_busy)
`ifdef PIPE_PARITY_EN
        , .parity_err(a_perr)
`endif
    );

    dsp_pipe_delay #(.WIDTH(W), .DEPTH(3), .CLR_DATA(0)) u_b (
        .CLK(CLK), .RST(RST), .CE(CE), .SCLR(SCLR),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(b_out_valid), .out_data(b_out_data),
        .occ(b_occ), .busy(b_busy)
`ifdef PIPE_PARITY_EN
        , .parity_err(b_perr)
`endif
    );

    dsp_pipe_delay #(.WIDTH(W), .DEPTH(0), .CLR_DATA(1)) u_z (
        .CLK(CLK), .RST(RST), .CE(CE), .SCLR(SCLR),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(z_out_valid), .out_data(z_out_data),
        .occ(z_occ), .busy(z_busy)
`ifdef PIPE_PARITY_EN
        , .parity_err(z_perr)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {valid, data}; index 0 = last stage (what the output shows)
    typedef logic [W:0] word_t;
    word_t qa[$];
    word_t qb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 3; i++) begin
            qa.push_back({(W+1){1'b0}});
            qb.push_back({(W+1){1'b0}});
        end
    endtask

    task automatic check_all(input string tag);
        int ca;
        int cb;
        ca = 0;
        cb = 0;
        for (int i = 0; i < 3; i++) begin
            ca += int'(qa[i][W]);
            cb += int'(qb[i][W]);
        end
        chk({tag, ".a_valid"}, 64'(a_out_valid), 64'(qa[0][W]));
        chk({tag, ".a_data"},  64'(a_out_data),  64'(qa[0][W-1:0]));
        chk({tag, ".a_occ"},   64'(a_occ),       64'(ca));
        chk({tag, ".a_busy"},  64'(a_busy),      64'(ca != 0));
        chk({tag, ".b_valid"}, 64'(b_out_valid), 64'(qb[0][W]));
        chk({tag, ".b_data"},  64'(b_out_data),  64'(qb[0][W-1:0]));
        chk({tag, ".b_occ"},   64'(b_occ),       64'(cb));
    endtask

    // One clock: drive inputs, take the edge, update expectations, compare.
    task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                        input logic ce = 1'b1, input logic sclr = 1'b0);
        CE       = ce;
        SCLR     = sclr;
        in_valid = v;
        in_data  = d;
        @(posedge CLK);
        #1;
        if (ce) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            if (sclr) begin
                qa.push_back({(W+1){1'b0}});
                for (int i = 0; i < 3; i++) qa[i] = {(W+1){1'b0}};
                qb.push_back({1'b0, d});
                for (int i = 0; i < 3; i++) qb[i][W] = 1'b0;
            end else begin
                qa.push_back({v, d});
                qb.push_back({v, d});
            end
        end
        check_all(tag);
    endtask

    logic [W-1:0] rd;

    initial begin
        RST      = 1'b1;
        CE       = 1'b0;
        SCLR     = 1'b0;
        in_valid = 1'b0;
        in_data  = {W{1'b0}};
        reset_model();
        #1;
        check_all("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Latency and fill/drain: data 1,2,3 back to back.
        step("fill1", 1'b1, 48'h1);
        chk("fill1.occ1", 64'(a_occ), 64'd1);
        step("fill2", 1'b1, 48'h2);
        step("fill3", 1'b1, 48'h3);
        chk("fill3.out1", 64'(a_out_data), 64'h1);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 48'h0);
        chk("drain.occ0", 64'(a_occ), 64'd0);

        // Bubble preserved: A, bubble, B.
        step("bub_a", 1'b1, 48'hA);
        step("bub_x", 1'b0, 48'h0);
        step("bub_b", 1'b1, 48'hB);
        for (int i = 0; i < 4; i++) step("bub_d", 1'b0, 48'h0);

        // CE freeze with two words in flight; freeze wins over in_valid.
        step("frz_w1", 1'b1, 48'h11);
        step("frz_w2", 1'b1, 48'h22);
        for (int i = 0; i < 4; i++) step("frz_hold", 1'b1, 48'hFF00 + 48'(i), 1'b0);
        for (int i = 0; i < 4; i++) step("frz_go", 1'b0, 48'h0);

        // SCLR with CE=1 on a full pipe; presented word is discarded.
        step("sclr_f1", 1'b1, 48'h31);
        step("sclr_f2", 1'b1, 48'h32);
        step("sclr_f3", 1'b1, 48'h33);
        step("sclr_ce1", 1'b1, 48'h34, 1'b1, 1'b1);
        chk("sclr_ce1.a_data0", 64'(a_out_data), 64'h0);
        step("sclr_after", 1'b0, 48'h0);
        // SCLR with CE=0 has no effect.
        step("sclr_g1", 1'b1, 48'h41);
        step("sclr_g2", 1'b1, 48'h42);
        step("sclr_g3", 1'b1, 48'h43);
        step("sclr_ce0", 1'b1, 48'h44, 1'b0, 1'b1);
        chk("sclr_ce0.a_occ3", 64'(a_occ), 64'd3);
        for (int i = 0; i < 3; i++) step("sclr_d", 1'b0, 48'h0);

        // Randomised mix of valid, CE and occasional SCLR.
        for (int i = 0; i < 40; i++) begin
            rd = {16'($urandom()), 32'($urandom())};
            step("rand", 1'($urandom_range(0, 1)), rd,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end

        // Async reset between edges with a full pipe.
        step("ar_f1", 1'b1, 48'h51);
        step("ar_f2", 1'b1, 48'h52);
        step("ar_f3", 1'b1, 48'h53);
        chk("ar.occ3", 64'(a_occ), 64'd3);
        RST = 1'b1;
        #1;
        chk("ar.valid0", 64'(a_out_valid), 64'd0);
        chk("ar.data0",  64'(a_out_data),  64'd0);
        chk("ar.occ0",   64'(a_occ),       64'd0);
        reset_model();
        @(posedge CLK);
        #1;
        check_all("ar_held");
        RST = 1'b0;
        step("ar_rel", 1'b1, 48'h61);
        for (int i = 0; i < 3; i++) step("ar_d", 1'b0, 48'h0);

        // DEPTH=0 bypass: same-cycle pass-through, control ignored.
        in_valid = 1'b1;
        in_data  = 48'hDEADBEEF;
        CE       = 1'b1;
        #1;
        chk("byp.data",  64'(z_out_data),  64'hDEADBEEF);
        chk("byp.valid", 64'(z_out_valid), 64'd1);
        chk("byp.occ",   64'(z_occ),       64'd0);
        chk("byp.busy",  64'(z_busy),      64'd0);
        CE       = 1'b0;
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = 48'h1234;
        #1;
        chk("byp_rst.data",  64'(z_out_data),  64'h1234);
        chk("byp_rst.valid", 64'(z_out_valid), 64'd0);
        RST = 1'b0;
        reset_model();

`ifdef PIPE_PARITY_EN
        // Corrupt the parity of one word; error appears the CE edge after it
        // is presented at the output and sticks until SCLR.
        chk("par.init", 64'(a_perr), 64'd0);
        force u_a.g_pipe.par_flip_s = 1'b1;
        step("par_w", 1'b1, 48'h5);
        release u_a.g_pipe.par_flip_s;
        chk("par.e1", 64'(a_perr), 64'd0);
        step("par_d2", 1'b0, 48'h0);
        chk("par.e2", 64'(a_perr), 64'd0);
        step("par_d3", 1'b0, 48'h0);
        chk("par.e3", 64'(a_perr), 64'd0);
        step("par_d4", 1'b0, 48'h0);
        chk("par.e4", 64'(a_perr), 64'd1);
        step("par_d5", 1'b1, 48'h7);
        step("par_d6", 1'b0, 48'h0, 1'b0, 1'b1);
        chk("par.stick", 64'(a_perr), 64'd1);
        chk("par.b_clean", 64'(b_perr), 64'd0);
        chk("par.z_tied", 64'(z_perr), 64'd0);
        step("par_clr", 1'b0, 48'h0, 1'b1, 1'b1);
        chk("par.clr", 64'(a_perr), 64'd0);
        step("par_end", 1'b0, 48'h0);
        chk("par.end", 64'(a_perr), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
